// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/HalfAdder.sv
// 1-bit half adder: building block of the full-adder cell.
module HalfAdder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b;
    assign carry = a & b;

endmodule

// File: rtl/full_adder.sv
// Combinational 1-bit full adder built from two half adders and an OR gate.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic ha0_sum;
    logic ha0_carry;
    logic ha1_carry;

    HalfAdder u_ha0 (
        .a     (a),
        .b     (b),
        .sum   (ha0_sum),
        .carry (ha0_carry)
    );

    HalfAdder u_ha1 (
        .a     (ha0_sum),
        .b     (cin),
        .sum   (sum),
        .carry (ha1_carry)
    );

    // At most one half adder can carry, so OR is sufficient.
    assign cout = ha0_carry | ha1_carry;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell and a carry flop add a+b+cin LSB first,
// one bit per clock; sum/cout/ovf are registered when the last bit completes.
//
// Handshake: start is sampled only in IDLE; busy is high for exactly WIDTH
// cycles while bits are processed, then done pulses for one cycle with the
// outputs already valid. start seen while busy or done is dropped, not queued.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output state_t           dbg_state
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-2:0] res_sr;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             fa_sum;
    logic             fa_cout;
    logic [WIDTH-1:0] res_full;
    logic             last_bit;

    full_adder u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // Result bits arrive LSB first and enter at the top, so after the last
    // bit the current cell output plus the shift register is the full sum.
    assign res_full = {fa_sum, res_sr};
    assign last_bit = (cnt == LAST_BIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr   <= a;
                        b_sr   <= b;
                        carry  <= cin;
                        res_sr <= '0;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    carry  <= fa_cout;
                    res_sr <= res_full[WIDTH-1:1];
                    if (last_bit) begin
                        cnt  <= '0;
                        sum  <= res_full;
                        cout <= fa_cout;
                        // Operand MSBs are in bit 0 of the shifters on the last bit.
                        ovf  <= (a_sr[0] == b_sr[0]) && (fa_sum != a_sr[0]);
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign dbg_state = state;

endmodule
